sd_req_arb: RTL

SD_REQ_ARB -- requirements
Module: sd_req_arb

---
 rtl/sd_req_arb.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sd_req_arb.sv
// Round-robin arbiter that multiplexes several virtual-drive sector requesters
// onto the single hps_io sd_rd/sd_wr channel, with a per-request ack timeout.
module sd_req_arb #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 16777216
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*32-1:0]   req_lba,
    input  logic [NREQ*16-1:0]   req_buff_din,
    output logic [NREQ-1:0]      req_busy,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic [NREQ-1:0]      req_buff_wr,
    output logic [31:0]          sd_lba,
    output logic [NREQ-1:0]      sd_rd,
    output logic [NREQ-1:0]      sd_wr,
    input  logic                 sd_ack,
    input  logic                 sd_buff_wr,
    output logic [15:0]          sd_buff_din
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     sel_q, sel_d;
    logic [31:0]       lba_q, lba_d;
    logic [NREQ-1:0]   rd_q, rd_d;
    logic [NREQ-1:0]   wr_q, wr_d;
    logic [NREQ-1:0]   busy_q, busy_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [NREQ-1:0]   pend;
    logic              gnt_found;
    logic [IW-1:0]     gnt_idx;
    logic [NREQ-1:0]   gnt_oh;
    logic [NREQ-1:0]   sel_oh;

    assign pend   = req_rd | req_wr;
    assign gnt_oh = NREQ'(1) << gnt_idx;
    assign sel_oh = NREQ'(1) << sel_q;

    // Search starts at ptr and wraps, so the most recently served requester goes last.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && pend[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        done_d  = '0;
        err_d   = '0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // Skip the cycle carrying an error pulse: the aborted requester
                // is still allowed to hold its request during that cycle.
                if (gnt_found && err_q == '0) begin
                    state_d = S_REQ;
                    sel_d   = gnt_idx;
                    lba_d   = req_lba[int'(gnt_idx)*32 +: 32];
                    if (req_rd[gnt_idx]) rd_d = gnt_oh;
                    else                 wr_d = gnt_oh;
                    busy_d  = gnt_oh;
                    ptr_d   = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + IW'(1);
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (sd_ack) begin
                    rd_d    = '0;
                    wr_d    = '0;
                    state_d = S_XFER;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    rd_d    = '0;
                    wr_d    = '0;
                    busy_d  = '0;
                    err_d   = sel_oh;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_XFER: begin
                if (!sd_ack) begin
                    done_d  = sel_oh;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            lba_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        req_buff_wr = '0;
        if (!reset && sd_buff_wr && sd_ack && (state_q == S_REQ || state_q == S_XFER))
            req_buff_wr = sel_oh;
    end

    assign sd_buff_din = req_buff_din[int'(sel_q)*16 +: 16];
    assign sd_lba      = lba_q;
    assign sd_rd       = rd_q;
    assign sd_wr       = wr_q;
    assign req_busy    = busy_q;
    assign req_done    = done_q;
    assign req_err     = err_q;

endmodule
